l2_out_merge: RTL and testbench
===============================

Name: l2_out_merge

Overview:
Parametrised N-channel output merger between the L2 core and the NoC plane interface.
- Each of NUM_CH outgoing L2 message channels (req_out, rsp_out, inval, stats, …) arrives flattened to DATA_W bits and is buffered in its own DEPTH-entry FIFO.
- Channels are round-robin arbitrated onto one registered output carrying a channel tag.
- Generalises the single-channel, unbuffered valid/ready wrapper ports to configurable width, depth and channel count, with fairness and backpressure isolation between channels.

Parameters:
- NUM_CH, 3, number of input channels (1..8).
- DATA_W, 160, flattened message width in bits.
- DEPTH, 4, per-channel FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  NUM_CH  per-channel valid.
- in_data  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  out  NUM_CH  per-channel ready.
- out_valid  out  1  merged output valid.
- out_data  out  DATA_W  merged message.
- out_ch  out  CH_W  source channel index; CH_W = max(1, $clog2(NUM_CH)).
- out_ready  in  1  downstream ready.
- stats_clr  in  1  clear statistics (feature only).
- stats_grant_cnt  out  NUM_CH*32  per-channel grant counts (feature only).
- stats_stall_cnt  out  32  output stall cycles (feature only).

Behaviour:
- Reset is synchronous and active-high on clk; one clock domain.
- Reset values:
  - all FIFOs empty, occupancy counts 0;
  - in_ready all 1 the cycle after reset deasserts;
  - out_valid 0, out_data 0, out_ch 0;
  - round-robin pointer 0;
  - stats counters 0.
- in_ready[i] = (count[i] != DEPTH). It depends only on FIFO fullness, never on same-cycle pops or out_ready (no combinational in→out path).
- Push on channel i when in_valid[i] && in_ready[i]. Data is written at wr_ptr[i], which wraps modulo DEPTH. Count width is $clog2(DEPTH)+1.
- Output register load condition: load = !out_valid || out_ready.
- When load is true:
  - If any FIFO is non-empty, grant the first non-empty channel searching from the rr pointer upward (mod NUM_CH).
  - Pop that channel and register its head into out_data/out_ch, setting out_valid = 1.
  - rr pointer becomes (grant+1) mod NUM_CH.
  - If all FIFOs are empty, out_valid goes to 0.
- While out_valid && !out_ready: out_data/out_ch are held stable and no pop occurs.
- Latency: a message pushed at edge E0 is earliest visible on out_valid after edge E1, given the output register is loadable.
- Throughput: 1 message/cycle aggregate with out_ready held high.
- Fairness: with all channels continuously non-empty, grants cycle 0,1,…,NUM_CH-1.
- Simultaneous push and pop on the same channel: count is unchanged and both pointers advance.
  - A full FIFO cannot push that cycle even if popped.
  - An empty FIFO cannot be popped by the same-cycle push (no bypass).
- Asserting rst mid-operation: all buffered and held messages are discarded, with no output handshake for them.
- Push data order is preserved per channel. No ordering is guaranteed across channels.

Optional Feature:
- Macro: L2_OUT_MERGE_STATS_EN.
- Defined:
  - stats_grant_cnt[i] increments on each pop of channel i.
  - stats_stall_cnt increments each cycle out_valid && !out_ready.
  - All counters are 32-bit and saturate at 0xFFFF_FFFF.
  - stats_clr zeroes all counters synchronously and takes priority over same-cycle increments.
- Undefined:
  - stats ports and counters are absent; no stats logic is synthesised.

Decomposition:
- cache_consts.svh: L2_OUT_MERGE default constants (NUM_CH, DATA_W, DEPTH).
- cache_types.svh: flattened message typedefs and the channel-index enum ordering (REQ_OUT=0, RSP_OUT=1, INVAL=2).
- Sub-module l2_merge_fifo (DATA_W, DEPTH): storage array, pointers, count, full/empty; instantiated NUM_CH times via generate.
- Arbiter and output register stay in l2_out_merge.

Test Plan:
- Reset then idle, NUM_CH=3, DEPTH=4 -> out_valid=0, in_ready=3'b111, out_ch=0.
- Single push on ch1 data=0xA5, out_ready=1 -> after next edge: out_valid=1, out_data=0xA5, out_ch=1; then out_valid=0.
- out_ready=0; push 5 messages on ch0 -> first fills output register, next 4 fill FIFO; in_ready[0]=0 after the 5th; out_data held unchanged; release out_ready -> 5 messages delivered in order on consecutive cycles.
- All 3 channels preloaded with 2 messages each, out_ready=1 -> out_ch sequence 0,1,2,0,1,2, no bubbles.
- Push 0x11 on ch2 and rst asserted in the same cycle -> no output ever shows 0x11; post-reset state matches reset values.
- L2_OUT_MERGE_STATS_EN: 4 grants on ch0 plus 3 stall cycles -> stats_grant_cnt[0]=4, stats_stall_cnt=3; stats_clr pulse -> all counters 0 next cycle.

Source files
------------

// File: rtl/l2_out_merge_pkg.sv
// Shared constants and types for the L2 output merger.
// Channel ordering matches the L2 core's outgoing message ports.
package l2_out_merge_pkg;

  localparam int L2_NUM_CH = 3;
  localparam int L2_DATA_W = 160;
  localparam int L2_DEPTH  = 4;

  typedef enum logic [1:0] {
    CH_REQ_OUT = 2'd0,
    CH_RSP_OUT = 2'd1,
    CH_INVAL   = 2'd2
  } l2_ch_e;

  typedef logic [L2_DATA_W-1:0] l2_msg_t;

  // Channel-tag width; a single channel still needs one tag bit.
  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/l2_merge_fifo.sv
// Per-channel DEPTH-entry FIFO with registered pointers and occupancy count.
// Head is read straight from storage so the arbiter can register it in one cycle.
module l2_merge_fifo #(
  parameter int DATA_W = 160,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  // Fullness/emptiness are taken from the registered count, so no same-cycle bypass.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/l2_out_merge.sv
// N-channel buffered round-robin merger onto one registered, channel-tagged output.
// Optional statistics counters are built when L2_OUT_MERGE_STATS_EN is defined.
module l2_out_merge
  import l2_out_merge_pkg::*;
#(
  parameter  int NUM_CH = L2_NUM_CH,
  parameter  int DATA_W = L2_DATA_W,
  parameter  int DEPTH  = L2_DEPTH,
  localparam int CH_W   = ch_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     out_ready
`ifdef L2_OUT_MERGE_STATS_EN
  ,
  input  logic                     stats_clr,
  output logic [NUM_CH*32-1:0]     stats_grant_cnt,
  output logic [31:0]              stats_stall_cnt
`endif
);

  logic [DATA_W-1:0] heads [NUM_CH];
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] pop;

  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic [CH_W-1:0]   out_ch_reg;
  logic [CH_W-1:0]   rr_reg;

  logic              load;
  logic              found;
  logic [CH_W-1:0]   grant;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      l2_merge_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
      ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid[gi]),
        .push_data (in_data[gi*DATA_W +: DATA_W]),
        .pop       (pop[gi]),
        .head      (heads[gi]),
        .full      (full[gi]),
        .empty     (empty[gi])
      );
      assign in_ready[gi] = !full[gi];
      assign pop[gi]      = load && found && (grant == CH_W'(gi));
    end
  endgenerate

  assign load = !out_valid_reg || out_ready;

  // First non-empty channel at or above the round-robin pointer, wrapping.
  always_comb begin
    int            sum;
    logic [CH_W-1:0] idx;
    found = 1'b0;
    grant = '0;
    sum   = 0;
    idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = int'(rr_reg) + k;
      if (sum >= NUM_CH) sum = sum - NUM_CH;
      idx = CH_W'(sum);
      if (!found && !empty[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      rr_reg        <= '0;
    end else if (load) begin
      if (found) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= heads[grant];
        out_ch_reg    <= grant;
        rr_reg        <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;

`ifdef L2_OUT_MERGE_STATS_EN
  logic [31:0] grant_cnt_reg [NUM_CH];
  logic [31:0] stall_cnt_reg;

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_stats
      always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
          grant_cnt_reg[gi] <= '0;
        end else if (pop[gi] && grant_cnt_reg[gi] != 32'hFFFF_FFFF) begin
          grant_cnt_reg[gi] <= grant_cnt_reg[gi] + 32'd1;
        end
      end
      assign stats_grant_cnt[gi*32 +: 32] = grant_cnt_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      stall_cnt_reg <= '0;
    end else if (out_valid_reg && !out_ready && stall_cnt_reg != 32'hFFFF_FFFF) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stats_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_l2_out_merge.sv
// Randomised bench for l2_out_merge against a queue-based reference model,
// plus directed scenarios with literal expectations.
module tb_l2_out_merge;
  import l2_out_merge_pkg::*;

  localparam int N  = 3;
  localparam int W  = 160;
  localparam int D  = 4;
  localparam int CW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [CW-1:0]  out_ch;
  logic           out_ready;
`ifdef L2_OUT_MERGE_STATS_EN
  logic           stats_clr;
  logic [N*32-1:0] stats_grant_cnt;
  logic [31:0]    stats_stall_cnt;
`endif

  l2_out_merge #(.NUM_CH(N), .DATA_W(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
`ifdef L2_OUT_MERGE_STATS_EN
    ,
    .stats_clr       (stats_clr),
    .stats_grant_cnt (stats_grant_cnt),
    .stats_stall_cnt (stats_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_msg();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: one queue per channel plus the output slot.
  logic [W-1:0] q [N][$];
  bit           m_ov;
  logic [W-1:0] m_data;
  int           m_ch;
  int           m_rr;
  longint       m_gcnt [N];
  longint       m_stall;

  always @(posedge clk) begin
    bit pushes [N];
    int g;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        q[i].delete();
        m_gcnt[i] = 0;
      end
      m_ov = 0; m_data = '0; m_ch = 0; m_rr = 0; m_stall = 0;
    end else begin
      for (int i = 0; i < N; i++) pushes[i] = in_valid[i] && (q[i].size() < D);
      if (m_ov && !out_ready) m_stall++;
      if (!m_ov || out_ready) begin
        g = -1;
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_rr + k) % N;
          if (g < 0 && q[c].size() > 0) g = c;
        end
        if (g >= 0) begin
          m_data = q[g].pop_front();
          m_ov = 1; m_ch = g; m_rr = (g + 1) % N;
          m_gcnt[g]++;
        end else begin
          m_ov = 0;
        end
      end
      for (int i = 0; i < N; i++)
        if (pushes[i]) q[i].push_back(in_data[i*W +: W]);
`ifdef L2_OUT_MERGE_STATS_EN
      if (stats_clr) begin
        for (int i = 0; i < N; i++) m_gcnt[i] = 0;
        m_stall = 0;
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_out_valid", W'(out_valid), W'(m_ov));
      if (m_ov) begin
        chk("model_out_data", out_data, m_data);
        chk("model_out_ch", W'(out_ch), W'(m_ch));
      end
      for (int i = 0; i < N; i++)
        chk("model_in_ready", W'(in_ready[i]), W'(q[i].size() < D));
`ifdef L2_OUT_MERGE_STATS_EN
      for (int i = 0; i < N; i++)
        chk("model_grant_cnt", W'(stats_grant_cnt[i*32 +: 32]), W'(m_gcnt[i][31:0]));
      chk("model_stall_cnt", W'(stats_stall_cnt), W'(m_stall[31:0]));
`endif
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [W-1:0] msgs [5];
  int           p_valid;
  int           p_ready;

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
`ifdef L2_OUT_MERGE_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    cmp_en = 1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", W'(out_valid), W'(0));
    chk("reset_in_ready", W'(in_ready), W'(3'b111));
    chk("reset_out_ch", W'(out_ch), W'(0));

    // Single message on channel 1.
    in_valid = 3'b010; in_data = '0; in_data[W +: W] = 160'hA5; out_ready = 1'b1;
    @(negedge clk);
    in_valid = '0;
    @(negedge clk);
    chk("single_valid", W'(out_valid), W'(1));
    chk("single_data", out_data, 160'hA5);
    chk("single_ch", W'(out_ch), W'(1));
    @(negedge clk);
    chk("single_drain", W'(out_valid), W'(0));

    // Backpressure: five messages on channel 0 while blocked.
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      msgs[j] = rand_msg();
      in_valid = 3'b001; in_data = '0; in_data[0 +: W] = msgs[j];
      @(negedge clk);
    end
    in_valid = '0;
    chk("bp_full", W'(in_ready[0]), W'(0));
    chk("bp_head", out_data, msgs[0]);
    @(negedge clk);
    chk("bp_hold", out_data, msgs[0]);
    out_ready = 1'b1;
    for (int j = 1; j < 5; j++) begin
      @(negedge clk);
      chk("bp_order_valid", W'(out_valid), W'(1));
      chk("bp_order_data", out_data, msgs[j]);
    end
    @(negedge clk);
    chk("bp_empty", W'(out_valid), W'(0));

    // Fairness: two messages preloaded on each channel.
    do_reset();
    out_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      in_valid = 3'b111;
      for (int i = 0; i < N; i++) in_data[i*W +: W] = rand_msg();
      @(negedge clk);
    end
    in_valid = '0;
    chk("rr_first_ch", W'(out_ch), W'(0));
    out_ready = 1'b1;
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      chk("rr_valid", W'(out_valid), W'(1));
      chk("rr_ch", W'(out_ch), W'(k % 3));
    end

    // Push coincident with reset is discarded.
    in_valid = 3'b100; in_data = '0; in_data[2*W +: W] = 160'h11;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rstpush_valid", W'(out_valid), W'(0));
      chk("rstpush_data", out_data, '0);
      chk("rstpush_ch", W'(out_ch), W'(0));
      chk("rstpush_ready", W'(in_ready), W'(3'b111));
    end

`ifdef L2_OUT_MERGE_STATS_EN
    do_reset();
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      in_valid = 3'b001; in_data[0 +: W] = rand_msg();
      @(negedge clk);
    end
    in_valid = '0;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("stats_grant0", W'(stats_grant_cnt[31:0]), W'(4));
    chk("stats_stall", W'(stats_stall_cnt), W'(3));
    out_ready = 1'b1; stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    chk("stats_clr_grant", W'(stats_grant_cnt), '0);
    chk("stats_clr_stall", W'(stats_stall_cnt), '0);
`endif

    // Randomised traffic with varying load and backpressure.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 500 == 0) begin
        p_valid = $urandom_range(10, 95);
        p_ready = $urandom_range(10, 100);
      end
      for (int i = 0; i < N; i++) begin
        in_valid[i] = ($urandom_range(0, 99) < p_valid);
        in_data[i*W +: W] = rand_msg();
      end
      out_ready = ($urandom_range(0, 99) < p_ready);
      rst = ($urandom_range(0, 299) == 0);
`ifdef L2_OUT_MERGE_STATS_EN
      stats_clr = ($urandom_range(0, 199) == 0);
`endif
      @(negedge clk);
    end
    rst = 1'b0; in_valid = '0; out_ready = 1'b1;
`ifdef L2_OUT_MERGE_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
